cnt_seg_display: RTL and testbench
==================================

# cnt_seg_display

Two-digit seven-segment display stage sitting directly downstream of the 6-bit up counter (count range 1..63). Samples the counter value into the `clk` domain and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. Drives a time-multiplexed, active-low, common-anode two-digit display with tens-digit blanking.

## Interface
- `REFRESH_DIV`, 100000: `clk` cycles per digit slot. Minimum 2.
- `BLANK_LEADING`, 1: when 1, the tens digit is blanked while it is 0.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low.
- `cnt_in` input 6: counter value. Produced on the divided clock and asynchronous to `clk`.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an` output 2: digit enables, active-low. `an[0]` selects ones, `an[1]` selects tens. Registered.
- `bcd_tens` output 4: latched tens digit, range 0..6.
- `bcd_ones` output 4: latched ones digit, range 0..9.
- `busy` output 1: high while a conversion is in progress (states CONV and DONE).

## Operation
- Input capture:
  - Two-flop sampler: `s1 <= cnt_in`, `s2 <= s1`.
  - The sample is stable when `s1 == s2`.
  - A request is raised when the sample is stable, `s2 != last_val`, and the FSM is in IDLE.
  - `last_val` resets to 0, so the post-reset counter value 1 is always converted.
- FSM states IDLE, CONV, DONE:
  - IDLE: on a request, load shift register `{tens=0, ones=0, bin=s2}`, set `last_val <= s2`, clear the iteration counter, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble that is >= 5, then shift the whole register left by 1. After the 6th shift, go to DONE.
  - DONE: copy the nibbles to `bcd_tens`/`bcd_ones`, return to IDLE.
- Changes to `cnt_in` while `busy` is high are not lost. On return to IDLE, the current stable sample is compared against `last_val` again, so the final value is always displayed.
- A `cnt_in` pulse lasting a single `clk` cycle never satisfies the stability check and is not converted.
- Scan:
  - A refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On each wrap, the digit select `sel` toggles.
- Registered outputs, updated every `clk` from the current `sel` and `bcd_*`:
  - `sel=0`: `an=2'b10`, `seg=decode(bcd_ones)`.
  - `sel=1`: `an=2'b01`, `seg=decode(bcd_tens)`.
  - `sel=1` with `BLANK_LEADING=1` and `bcd_tens==0`: `an=2'b11`, `seg=7'h7F`.
- Decode values (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Any other value maps to 7F.
- Width rules: input maximum is 63, so tens <= 6 and no third digit exists. The shift register is 14 bits (4+4+6).

## Timing
- Reset values (asynchronous, while `reset` is low):
  - `seg=7'h7F`, `an=2'b11`, `bcd_tens=0`, `bcd_ones=0`, `busy=0`.
  - `s1=s2=last_val=0`, state IDLE, refresh counter 0, `sel=0`.
- Reset asserted mid-conversion aborts the conversion immediately. After release, the current input is converted anew.
- Conversion latency, with `cnt_in` changing before edge k:
  - `s1` updates at k+1, `s2` at k+2.
  - Load and entry to CONV at k+3.
  - Shifts at k+4..k+9.
  - `bcd_*` updated at k+10.
  - `busy` is high from after k+3 until after k+10.
- Display latency: `seg`/`an` reflect new `bcd_*` or a new `sel` one clock later.
- First edge after reset release: `an=2'b10`, `seg=7'h40`.
- Digit period: each digit is enabled for exactly `REFRESH_DIV` cycles. There is no dead time between slots.

## Test plan
- Reset check:
  - While `reset` is low: `seg=7F`, `an=11`, `bcd=0/0`, `busy=0`.
  - After release with `cnt_in=0`: `an=10`, `seg=40`, `busy` stays 0.
- `cnt_in=1` changing before edge k, `REFRESH_DIV=4`: `busy` high k+3..k+10, `bcd_ones=1`, `bcd_tens=0` after k+10, tens slot blanked (`an=11`, `seg=7F`).
- `cnt_in=63`, `REFRESH_DIV=4`: `bcd=6/3`. Output alternates every 4 cycles between `an=10`/`seg=30` and `an=01`/`seg=02`.
- Wrap 63 -> 1, then `BLANK_LEADING=0` build with `cnt_in=5`:
  - 63 -> 1: tens goes 6 -> 0 and the tens slot becomes blanked.
  - `BLANK_LEADING=0`, `cnt_in=5`: tens slot shows `an=01`, `seg=40`.
- `cnt_in=10`, then `cnt_in=42` three cycles after the first conversion starts:
  - `bcd` goes 1/0 first, then 4/2.
  - Exactly two conversions occur.
  - A single-cycle pulse to 7 is never converted.
- `reset` asserted during CONV (input 37): outputs return to reset values immediately. After release, `bcd=3/7` within 10 clocks.

Source files
------------

// File: rtl/cnt_seg_display.sv
// Two-digit seven-segment stage: samples the 6-bit counter, converts it to BCD
// with a sequential double-dabble engine, and scans an active-low common-anode display.
module cnt_seg_display #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] cnt_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  s1_q, s2_q, last_q;
  logic [13:0] sh_q, sh_d, adj;
  logic [2:0]  iter_q;
  logic [3:0]  tens_q, ones_q;
  logic [CW-1:0] ref_q;
  logic        sel_q;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  an_q, an_d;
  logic        req, load, shift, done;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // A value is only accepted once both sampler flops agree, so a one-cycle glitch is ignored.
  assign req = (s1_q == s2_q) && (s2_q != last_q) && (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = CONV;
      CONV:    if (iter_q == 3'd5) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    load  = req;
      CONV:    shift = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    adj = sh_q;
    if (sh_q[13:10] >= 4'd5) adj[13:10] = sh_q[13:10] + 4'd3;
    if (sh_q[9:6]   >= 4'd5) adj[9:6]   = sh_q[9:6] + 4'd3;
    sh_d = {adj[12:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      last_q <= '0;
      sh_q   <= '0;
      iter_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      s1_q <= cnt_in;
      s2_q <= s1_q;
      if (load) begin
        sh_q   <= {8'd0, s2_q};
        last_q <= s2_q;
        iter_q <= '0;
      end else if (shift) begin
        sh_q   <= sh_d;
        iter_q <= iter_q + 3'd1;
      end
      if (done) begin
        tens_q <= sh_q[13:10];
        ones_q <= sh_q[9:6];
      end
    end
  end

  always_comb begin
    an_d  = 2'b10;
    seg_d = decode(ones_q);
    if (sel_q) begin
      if ((BLANK_LEADING != 0) && (tens_q == 4'd0)) begin
        an_d  = 2'b11;
        seg_d = 7'h7F;
      end else begin
        an_d  = 2'b01;
        seg_d = decode(tens_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q <= '0;
      sel_q <= 1'b0;
      seg_q <= 7'h7F;
      an_q  <= 2'b11;
    end else begin
      if (ref_q == CW'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        sel_q <= ~sel_q;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

endmodule

// File: tb/tb_cnt_seg_display.sv
// Bench for cnt_seg_display: random and directed counter values, decimal reference
// model feeding an expected-digit queue, and a per-cycle display scan model.
module tb_cnt_seg_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] cnt_in = 6'd0;

  logic [6:0] seg, seg_nb;
  logic [1:0] an, an_nb;
  logic [3:0] bcd_tens, bcd_ones, bcd_tens_nb, bcd_ones_nb;
  logic       busy, busy_nb;
  logic [1:0] dbg_state, dbg_state_nb;

  cnt_seg_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in),
    .seg(seg), .an(an), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .busy(busy), .dbg_state(dbg_state)
  );

  cnt_seg_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .reset(reset), .cnt_in(cnt_in),
    .seg(seg_nb), .an(an_nb), .bcd_tens(bcd_tens_nb), .bcd_ones(bcd_ones_nb),
    .busy(busy_nb), .dbg_state(dbg_state_nb)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [5:0] last_pushed = 6'd0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         n_edges = 0;
  logic [3:0] disp_t = 4'd0;
  logic [3:0] disp_o = 4'd0;
  logic       prev_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int   sel;
    logic [6:0] e_seg, e_seg_nb;
    logic [1:0] e_an, e_an_nb;
    logic [7:0] e;
    if (!reset) begin
      check("rst_seg", seg, 7'h7F);
      check("rst_an", an, 2'b11);
      check("rst_tens", bcd_tens, 0);
      check("rst_ones", bcd_ones, 0);
      check("rst_busy", busy, 0);
      n_edges   = 0;
      disp_t    = 4'd0;
      disp_o    = 4'd0;
      prev_busy = 1'b0;
    end else begin
      n_edges++;
      sel = ((n_edges - 1) / DIV) % 2;
      if (sel == 0) begin
        e_an = 2'b10; e_seg = seg_tab[disp_o];
        e_an_nb = 2'b10; e_seg_nb = seg_tab[disp_o];
      end else begin
        e_an_nb = 2'b01; e_seg_nb = seg_tab[disp_t];
        if (disp_t == 0) begin
          e_an = 2'b11; e_seg = 7'h7F;
        end else begin
          e_an = 2'b01; e_seg = seg_tab[disp_t];
        end
      end
      check("scan_an", an, e_an);
      check("scan_seg", seg, e_seg);
      check("scan_an_noblank", an_nb, e_an_nb);
      check("scan_seg_noblank", seg_nb, e_seg_nb);
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL conv_unexpected: got %0d/%0d expected no conversion at %0t",
                   bcd_tens, bcd_ones, $time);
        end else begin
          e = exp_q.pop_front();
          check("conv_bcd", {bcd_tens, bcd_ones}, e);
          disp_t = e[7:4];
          disp_o = e[3:0];
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_val(input logic [5:0] v, input int hold);
    @(posedge clk);
    #1 cnt_in = v;
    if (v != last_pushed) begin
      exp_q.push_back(to_bcd(v));
      last_pushed = v;
    end
    repeat (hold) @(posedge clk);
  endtask

  task automatic pulse(input logic [5:0] v);
    logic [5:0] old;
    @(posedge clk);
    #1 old = cnt_in;
    cnt_in = v;
    @(posedge clk);
    #1 cnt_in = old;
    repeat (12) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);

    // latency of a single conversion of value 1
    @(posedge clk);
    #1 cnt_in = 6'd1;
    exp_q.push_back(to_bcd(1));
    last_pushed = 6'd1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 2 || j == 10) check("busy_low", busy, 0);
      if (j == 3 || j == 9)  check("busy_high", busy, 1);
      if (j == 10) begin
        check("lat_ones", bcd_ones, 1);
        check("lat_tens", bcd_tens, 0);
      end
    end
    repeat (12) @(posedge clk);

    set_val(6'd63, 30);
    set_val(6'd1, 20);
    set_val(6'd5, 20);

    // second value arrives while the first is converting; then a one-cycle glitch
    set_val(6'd10, 5);
    set_val(6'd42, 25);
    pulse(6'd7);

    for (int i = 0; i < 15; i++) begin
      set_val(6'($urandom_range(1, 63)), $urandom_range(12, 20));
      if ($urandom_range(0, 3) == 0) pulse(6'($urandom_range(0, 63)));
    end

    // reset in the middle of converting 37
    set_val(6'd37, 5);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(to_bcd(37));
    last_pushed = 6'd37;
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_tens", bcd_tens, 3);
    check("post_rst_ones", bcd_ones, 7);

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
    end
    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
